dm_sba_ctrl: RTL and testbench

Debug-module System Bus Access controller, the successor to the existing SBA block. It turns sbaddress/sbdata register accesses into single-beat bus transactions on a 32- or 64-bit master port. New relative to the current block: the command is latched at launch; alignment, size, bus-error and timeout checks; a sticky busy-error; sub-word read-lane extraction and write-lane replication. It sits between the DM CSR block and the SoC bus host adapter.

---
 rtl/dm_sba_pkg.sv | 35 +++
 rtl/dm_sba_lane.sv | 46 ++++
 rtl/dm_sba_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_dm_sba_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sba_pkg.sv
// Shared types and helpers for the debug-module system bus access controller.
//   sba_state_e    : controller FSM states
//   sba_err_e      : sberror codes reported to the DM CSR block
//   size_to_bmask  : log2 access size -> unshifted byte mask (up to 8 bytes)
package dm_sba_pkg;

    typedef enum logic [2:0] {
        SbaIdle      = 3'd0,
        SbaRead      = 3'd1,
        SbaWrite     = 3'd2,
        SbaWaitRead  = 3'd3,
        SbaWaitWrite = 3'd4
    } sba_state_e;

    typedef enum logic [2:0] {
        SbErrNone    = 3'd0,
        SbErrTimeout = 3'd1,
        SbErrBadAddr = 3'd2,
        SbErrAlign   = 3'd3,
        SbErrSize    = 3'd4
    } sba_err_e;

    // Byte mask covering 2^size bytes, right-aligned.
    function automatic logic [7:0] size_to_bmask(input logic [2:0] size);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for single-beat bus accesses (purely combinational).
//   off_i   : byte offset of the access inside the bus word
//   size_i  : log2 access size in bytes (assumed legal for BusWidth)
//   wdata_i : right-aligned write data
//   rdata_i : raw bus read data
//   be_o    : byte enables, mask shifted to the offset
//   wdata_o : low 2^size bytes of wdata_i replicated over all lanes
//   rdata_o : read data shifted down to bit 0 and masked to the access size
module dm_sba_lane import dm_sba_pkg::*; #(
    parameter int unsigned BusWidth = 32
) (
    input  logic [$clog2(BusWidth/8)-1:0] off_i,
    input  logic [2:0]                    size_i,
    input  logic [BusWidth-1:0]           wdata_i,
    input  logic [BusWidth-1:0]           rdata_i,
    output logic [BusWidth/8-1:0]         be_o,
    output logic [BusWidth-1:0]           wdata_o,
    output logic [BusWidth-1:0]           rdata_o
);

    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);

    logic [NumBytes-1:0] bmask;
    logic [OffW-1:0]     lane_mask;
    logic [BusWidth-1:0] rshift;

    assign bmask     = NumBytes'(size_to_bmask(size_i));
    assign lane_mask = OffW'((32'd1 << size_i) - 32'd1);
    assign be_o      = bmask << off_i;
    assign rshift    = rdata_i >> {off_i, 3'b000};

    // Replicate write bytes and mask read bytes lane by lane.
    always_comb begin
        logic [OffW-1:0] idx;
        idx     = '0;
        wdata_o = '0;
        rdata_o = '0;
        for (int unsigned b = 0; b < NumBytes; b++) begin
            idx = OffW'(b) & lane_mask;
            wdata_o[b*8 +: 8] = wdata_i[{idx, 3'b000} +: 8];
            rdata_o[b*8 +: 8] = bmask[b] ? rshift[b*8 +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/dm_sba_ctrl.sv
// System Bus Access controller: turns sbaddress/sbdata CSR accesses into
// single-beat transactions on a 32/64-bit bus master port, with size,
// alignment, bus-error and timeout checks plus a sticky busy error.
//   clk_i, rst_ni            : clock, async active-low reset
//   dmactive_i               : low = synchronous soft reset
//   master_*                 : bus host adapter port
//   sbaddress_*, sbdata_*,
//   sbaccess_i, sbread*_i,
//   sbautoincrement_i        : DM CSR interface (triggers and config)
//   sbbusy_o, sbbusyerror_o,
//   sberror_*                : status back to the CSR block
module dm_sba_ctrl import dm_sba_pkg::*; #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic                  sbaddress_valid_o,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    input  logic                  sbbusyerror_clear_i,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);

    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned MaxSize  = OffW;
    localparam int unsigned CntW     = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

    if (!(BusWidth == 32 || BusWidth == 64)) begin : g_bad_width
        $error("dm_sba_ctrl: BusWidth must be 32 or 64");
    end

    sba_state_e          state_q, state_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [BusWidth-1:0] data_q, data_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                busyerr_q, busyerr_d;
    logic [BusWidth-1:0] sbdata_q, sbdata_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
    logic                sbaddress_valid_q, sbaddress_valid_d;
    logic [2:0]          sberror_q, sberror_d;
    logic                sberror_valid_q, sberror_valid_d;

    logic                trig_w, trig_r, trig_any;
    logic [BusWidth-1:0] align_mask;
    logic [NumBytes-1:0] lane_be;
    logic [BusWidth-1:0] lane_wdata, lane_rdata;

    assign trig_w     = sbdata_write_valid_i;
    assign trig_r     = (sbaddress_write_valid_i && sbreadonaddr_i)
                     || (sbdata_read_valid_i && sbreadondata_i);
    assign trig_any   = trig_w || trig_r;
    assign align_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);

    // Lane steering always works on the command latched at launch.
    dm_sba_lane #(.BusWidth(BusWidth)) u_lane (
        .off_i   (addr_q[OffW-1:0]),
        .size_i  (size_q),
        .wdata_i (data_q),
        .rdata_i (master_r_rdata_i),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    // Next-state and output logic.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        size_d            = size_q;
        data_d            = data_q;
        cnt_d             = cnt_q;
        busyerr_d         = busyerr_q;
        sbdata_d          = sbdata_q;
        sbdata_valid_d    = 1'b0;
        sbaddress_d       = sbaddress_q;
        sbaddress_valid_d = 1'b0;
        sberror_d         = SbErrNone;
        sberror_valid_d   = 1'b0;

        if (sbbusyerror_clear_i) busyerr_d = 1'b0;

        case (state_q)
            SbaIdle: begin
                if (trig_any) begin
                    if (sbaccess_i > 3'(MaxSize)) begin
                        sberror_d       = SbErrSize;
                        sberror_valid_d = 1'b1;
                    end else if ((sbaddress_i & align_mask) != '0) begin
                        sberror_d       = SbErrAlign;
                        sberror_valid_d = 1'b1;
                    end else begin
                        addr_d  = sbaddress_i;
                        size_d  = sbaccess_i;
                        data_d  = sbdata_i;
                        cnt_d   = '0;
                        state_d = trig_w ? SbaWrite : SbaRead;
                    end
                end
            end
            SbaRead:  if (master_gnt_i) state_d = SbaWaitRead;
            SbaWrite: if (master_gnt_i) state_d = SbaWaitWrite;
            SbaWaitRead, SbaWaitWrite: begin
                if (master_r_valid_i) begin
                    if (state_q == SbaWaitRead) begin
                        sbdata_d       = lane_rdata;
                        sbdata_valid_d = 1'b1;
                    end else begin
                        sbdata_d = '0;
                    end
                    if (master_r_err_i) begin
                        sberror_d       = SbErrBadAddr;
                        sberror_valid_d = 1'b1;
                    end else if (sbautoincrement_i) begin
                        sbaddress_d       = addr_q + (BusWidth'(1) << size_q);
                        sbaddress_valid_d = 1'b1;
                    end
                    state_d = SbaIdle;
                end
            end
            default: state_d = SbaIdle;
        endcase

        // Busy error has priority over a same-cycle clear; timeout only
        // fires if the transaction would otherwise still be outstanding.
        if (state_q != SbaIdle) begin
            if (trig_any) busyerr_d = 1'b1;
            if (TimeoutCycles != 0) begin
                cnt_d = cnt_q + CntW'(1);
                if (state_d != SbaIdle && cnt_d >= CntW'(TimeoutCycles)) begin
                    sberror_d       = SbErrTimeout;
                    sberror_valid_d = 1'b1;
                    state_d         = SbaIdle;
                end
            end
        end

        if (!dmactive_i) begin
            state_d           = SbaIdle;
            cnt_d             = '0;
            busyerr_d         = 1'b0;
            sbdata_d          = sbdata_q;
            sbdata_valid_d    = 1'b0;
            sbaddress_d       = sbaddress_q;
            sbaddress_valid_d = 1'b0;
            sberror_d         = SbErrNone;
            sberror_valid_d   = 1'b0;
        end

        req_d  = (state_d == SbaRead) || (state_d == SbaWrite);
        we_d   = (state_d == SbaWrite);
        busy_d = (state_d != SbaIdle);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= SbaIdle;
            addr_q            <= '0;
            size_q            <= '0;
            data_q            <= '0;
            cnt_q             <= '0;
            req_q             <= 1'b0;
            we_q              <= 1'b0;
            busy_q            <= 1'b0;
            busyerr_q         <= 1'b0;
            sbdata_q          <= '0;
            sbdata_valid_q    <= 1'b0;
            sbaddress_q       <= '0;
            sbaddress_valid_q <= 1'b0;
            sberror_q         <= '0;
            sberror_valid_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            size_q            <= size_d;
            data_q            <= data_d;
            cnt_q             <= cnt_d;
            req_q             <= req_d;
            we_q              <= we_d;
            busy_q            <= busy_d;
            busyerr_q         <= busyerr_d;
            sbdata_q          <= sbdata_d;
            sbdata_valid_q    <= sbdata_valid_d;
            sbaddress_q       <= sbaddress_d;
            sbaddress_valid_q <= sbaddress_valid_d;
            sberror_q         <= sberror_d;
            sberror_valid_q   <= sberror_valid_d;
        end
    end

    assign master_req_o      = req_q;
    assign master_add_o      = addr_q;
    assign master_we_o       = we_q;
    assign master_wdata_o    = lane_wdata;
    // Enables are only meaningful while requesting; keep them 0 otherwise.
    assign master_be_o       = req_q ? lane_be : '0;
    assign sbaddress_o       = sbaddress_q;
    assign sbaddress_valid_o = sbaddress_valid_q;
    assign sbdata_o          = sbdata_q;
    assign sbdata_valid_o    = sbdata_valid_q;
    assign sbbusy_o          = busy_q;
    assign sbbusyerror_o     = busyerr_q;
    assign sberror_valid_o   = sberror_valid_q;
    assign sberror_o         = sberror_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Directed bench: a 64-bit instance (default timeout) and a 32-bit instance
// with an 8-cycle timeout. Inputs change on the falling edge, outputs are
// sampled on the falling edge after the rising edge that updates them.
module tb_dm_sba_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- 64-bit instance ----------------
    logic        a_dmactive, a_req, a_we, a_gnt, a_rvalid, a_rerr;
    logic [63:0] a_add, a_wdata, a_rdata, a_sbaddress_i, a_sbaddress_o, a_sbdata_i, a_sbdata_o;
    logic [7:0]  a_be;
    logic        a_addr_wv, a_rdonaddr, a_sbaddress_valid, a_autoinc, a_rdondata;
    logic [2:0]  a_sbaccess, a_sberr;
    logic        a_data_rv, a_data_wv, a_sbdata_valid, a_busy, a_busyerr, a_busyerr_clr, a_sberr_valid;

    dm_sba_ctrl #(.BusWidth(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(a_dmactive),
        .master_req_o(a_req), .master_add_o(a_add), .master_we_o(a_we),
        .master_wdata_o(a_wdata), .master_be_o(a_be), .master_gnt_i(a_gnt),
        .master_r_valid_i(a_rvalid), .master_r_err_i(a_rerr), .master_r_rdata_i(a_rdata),
        .sbaddress_i(a_sbaddress_i), .sbaddress_write_valid_i(a_addr_wv),
        .sbreadonaddr_i(a_rdonaddr), .sbaddress_o(a_sbaddress_o),
        .sbaddress_valid_o(a_sbaddress_valid), .sbautoincrement_i(a_autoinc),
        .sbaccess_i(a_sbaccess), .sbreadondata_i(a_rdondata), .sbdata_i(a_sbdata_i),
        .sbdata_read_valid_i(a_data_rv), .sbdata_write_valid_i(a_data_wv),
        .sbdata_o(a_sbdata_o), .sbdata_valid_o(a_sbdata_valid), .sbbusy_o(a_busy),
        .sbbusyerror_o(a_busyerr), .sbbusyerror_clear_i(a_busyerr_clr),
        .sberror_valid_o(a_sberr_valid), .sberror_o(a_sberr)
    );

    // ---------------- 32-bit instance ----------------
    logic        b_dmactive, b_req, b_we, b_gnt, b_rvalid, b_rerr;
    logic [31:0] b_add, b_wdata, b_rdata, b_sbaddress_i, b_sbaddress_o, b_sbdata_i, b_sbdata_o;
    logic [3:0]  b_be;
    logic        b_addr_wv, b_rdonaddr, b_sbaddress_valid, b_autoinc, b_rdondata;
    logic [2:0]  b_sbaccess, b_sberr;
    logic        b_data_rv, b_data_wv, b_sbdata_valid, b_busy, b_busyerr, b_busyerr_clr, b_sberr_valid;

    dm_sba_ctrl #(.BusWidth(32), .TimeoutCycles(8)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(b_dmactive),
        .master_req_o(b_req), .master_add_o(b_add), .master_we_o(b_we),
        .master_wdata_o(b_wdata), .master_be_o(b_be), .master_gnt_i(b_gnt),
        .master_r_valid_i(b_rvalid), .master_r_err_i(b_rerr), .master_r_rdata_i(b_rdata),
        .sbaddress_i(b_sbaddress_i), .sbaddress_write_valid_i(b_addr_wv),
        .sbreadonaddr_i(b_rdonaddr), .sbaddress_o(b_sbaddress_o),
        .sbaddress_valid_o(b_sbaddress_valid), .sbautoincrement_i(b_autoinc),
        .sbaccess_i(b_sbaccess), .sbreadondata_i(b_rdondata), .sbdata_i(b_sbdata_i),
        .sbdata_read_valid_i(b_data_rv), .sbdata_write_valid_i(b_data_wv),
        .sbdata_o(b_sbdata_o), .sbdata_valid_o(b_sbdata_valid), .sbbusy_o(b_busy),
        .sbbusyerror_o(b_busyerr), .sbbusyerror_clear_i(b_busyerr_clr),
        .sberror_valid_o(b_sberr_valid), .sberror_o(b_sberr)
    );

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int  req_cyc;
        bit  seen;

        rst_n = 1'b0;
        a_dmactive = 1'b1; a_gnt = 1'b0; a_rvalid = 1'b0; a_rerr = 1'b0; a_rdata = '0;
        a_sbaddress_i = '0; a_addr_wv = 1'b0; a_rdonaddr = 1'b0; a_autoinc = 1'b0;
        a_sbaccess = '0; a_rdondata = 1'b0; a_sbdata_i = '0; a_data_rv = 1'b0;
        a_data_wv = 1'b0; a_busyerr_clr = 1'b0;
        b_dmactive = 1'b1; b_gnt = 1'b0; b_rvalid = 1'b0; b_rerr = 1'b0; b_rdata = '0;
        b_sbaddress_i = '0; b_addr_wv = 1'b0; b_rdonaddr = 1'b0; b_autoinc = 1'b0;
        b_sbaccess = '0; b_rdondata = 1'b0; b_sbdata_i = '0; b_data_rv = 1'b0;
        b_data_wv = 1'b0; b_busyerr_clr = 1'b0;

        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_req",     {63'd0, a_req}, 64'd0);
        chk("rst_be",      {56'd0, a_be}, 64'd0);
        chk("rst_wdata",   a_wdata, 64'd0);
        chk("rst_busy",    {63'd0, a_busy}, 64'd0);
        chk("rst_busyerr", {63'd0, a_busyerr}, 64'd0);
        chk("rst_sberrv",  {63'd0, a_sberr_valid}, 64'd0);
        chk("rst_sbdata",  a_sbdata_o, 64'd0);
        chk("rst_b_be",    {60'd0, b_be}, 64'd0);
        chk("rst_b_busy",  {63'd0, b_busy}, 64'd0);

        // 32-bit read at 0x1004 on the 64-bit bus
        a_sbaddress_i = 64'h1004; a_sbaccess = 3'd2; a_addr_wv = 1'b1; a_rdonaddr = 1'b1;
        step();
        a_addr_wv = 1'b0; a_rdonaddr = 1'b0;
        chk("rd_req",  {63'd0, a_req}, 64'd1);
        chk("rd_we",   {63'd0, a_we}, 64'd0);
        chk("rd_add",  a_add, 64'h1004);
        chk("rd_be",   {56'd0, a_be}, 64'hF0);
        chk("rd_busy", {63'd0, a_busy}, 64'd1);
        a_gnt = 1'b1;
        step();
        a_gnt = 1'b0;
        chk("rd_req_gnt", {63'd0, a_req}, 64'd0);
        a_rvalid = 1'b1; a_rdata = 64'hAABBCCDD_11223344;
        step();
        a_rvalid = 1'b0;
        chk("rd_data",  a_sbdata_o, 64'hAABBCCDD);
        chk("rd_valid", {63'd0, a_sbdata_valid}, 64'd1);
        chk("rd_idle",  {63'd0, a_busy}, 64'd0);
        step();
        chk("rd_valid_pulse", {63'd0, a_sbdata_valid}, 64'd0);

        // Misaligned 16-bit write at 0x1003
        a_sbaddress_i = 64'h1003; a_sbaccess = 3'd1; a_data_wv = 1'b1;
        step();
        a_data_wv = 1'b0;
        chk("al_err",   {61'd0, a_sberr}, 64'd3);
        chk("al_errv",  {63'd0, a_sberr_valid}, 64'd1);
        chk("al_req",   {63'd0, a_req}, 64'd0);
        chk("al_busy",  {63'd0, a_busy}, 64'd0);
        step();
        chk("al_errv_pulse", {63'd0, a_sberr_valid}, 64'd0);

        // Byte write at 0x2005 with bus error: replication, no autoincrement
        a_autoinc = 1'b1;
        a_sbaddress_i = 64'h2005; a_sbaccess = 3'd0; a_sbdata_i = 64'h12345678_9ABCDE5A; a_data_wv = 1'b1;
        step();
        a_data_wv = 1'b0;
        chk("bw_we",    {63'd0, a_we}, 64'd1);
        chk("bw_be",    {56'd0, a_be}, 64'h20);
        chk("bw_wdata", a_wdata, 64'h5A5A5A5A_5A5A5A5A);
        a_gnt = 1'b1;
        step();
        a_gnt = 1'b0;
        a_rvalid = 1'b1; a_rerr = 1'b1;
        step();
        a_rvalid = 1'b0; a_rerr = 1'b0;
        chk("bw_err",    {61'd0, a_sberr}, 64'd2);
        chk("bw_errv",   {63'd0, a_sberr_valid}, 64'd1);
        chk("bw_noinc",  {63'd0, a_sbaddress_valid}, 64'd0);
        chk("bw_nodv",   {63'd0, a_sbdata_valid}, 64'd0);
        chk("bw_sbdata", a_sbdata_o, 64'd0);

        // 64-bit write at 0x2008 with autoincrement
        a_sbaddress_i = 64'h2008; a_sbaccess = 3'd3; a_sbdata_i = 64'h01234567_89ABCDEF; a_data_wv = 1'b1;
        step();
        a_data_wv = 1'b0;
        chk("dw_be",    {56'd0, a_be}, 64'hFF);
        chk("dw_wdata", a_wdata, 64'h01234567_89ABCDEF);
        a_gnt = 1'b1;
        step();
        a_gnt = 1'b0; a_rvalid = 1'b1;
        step();
        a_rvalid = 1'b0;
        chk("dw_inc",   a_sbaddress_o, 64'h2010);
        chk("dw_incv",  {63'd0, a_sbaddress_valid}, 64'd1);
        chk("dw_noerr", {63'd0, a_sberr_valid}, 64'd0);
        step();
        chk("dw_incv_pulse", {63'd0, a_sbaddress_valid}, 64'd0);

        // Trigger during WaitRead: sticky busy error, original read completes
        a_autoinc = 1'b0;
        a_sbaddress_i = 64'h1008; a_sbaccess = 3'd3; a_addr_wv = 1'b1; a_rdonaddr = 1'b1;
        step();
        a_addr_wv = 1'b0; a_rdonaddr = 1'b0; a_gnt = 1'b1;
        step();
        a_gnt = 1'b0; a_sbaddress_i = 64'h3000; a_data_wv = 1'b1;
        step();
        a_data_wv = 1'b0;
        chk("be_set",  {63'd0, a_busyerr}, 64'd1);
        chk("be_busy", {63'd0, a_busy}, 64'd1);
        chk("be_req",  {63'd0, a_req}, 64'd0);
        a_rvalid = 1'b1; a_rdata = 64'h11223344_55667788;
        step();
        a_rvalid = 1'b0;
        chk("be_rdata",  a_sbdata_o, 64'h11223344_55667788);
        chk("be_rvalid", {63'd0, a_sbdata_valid}, 64'd1);
        chk("be_idle",   {63'd0, a_busy}, 64'd0);
        step();
        chk("be_sticky", {63'd0, a_busyerr}, 64'd1);
        a_busyerr_clr = 1'b1;
        step();
        a_busyerr_clr = 1'b0;
        chk("be_clear", {63'd0, a_busyerr}, 64'd0);

        // dmactive low mid-transaction (read on sbdata read)
        a_sbaddress_i = 64'h1010; a_sbaccess = 3'd2; a_data_rv = 1'b1; a_rdondata = 1'b1;
        step();
        a_data_rv = 1'b0; a_rdondata = 1'b0;
        chk("dm_req", {63'd0, a_req}, 64'd1);
        chk("dm_add", a_add, 64'h1010);
        a_addr_wv = 1'b1; a_rdonaddr = 1'b1;
        step();
        a_addr_wv = 1'b0; a_rdonaddr = 1'b0;
        chk("dm_berr", {63'd0, a_busyerr}, 64'd1);
        a_dmactive = 1'b0;
        step();
        a_dmactive = 1'b1;
        chk("dm_busy",  {63'd0, a_busy}, 64'd0);
        chk("dm_req0",  {63'd0, a_req}, 64'd0);
        chk("dm_berr0", {63'd0, a_busyerr}, 64'd0);
        a_rvalid = 1'b1;
        step();
        a_rvalid = 1'b0;
        chk("dm_late_dv", {63'd0, a_sbdata_valid}, 64'd0);

        // 32-bit bus: 64-bit access is too large
        b_sbaddress_i = 32'h0; b_sbaccess = 3'd3; b_addr_wv = 1'b1; b_rdonaddr = 1'b1;
        step();
        b_addr_wv = 1'b0; b_rdonaddr = 1'b0;
        chk("sz_err",  {61'd0, b_sberr}, 64'd4);
        chk("sz_errv", {63'd0, b_sberr_valid}, 64'd1);
        chk("sz_req",  {63'd0, b_req}, 64'd0);

        // Autoincrement byte write at 0xFFFFFFFF, grant after 3 cycles, wraps to 0
        b_autoinc = 1'b1;
        b_sbaddress_i = 32'hFFFF_FFFF; b_sbaccess = 3'd0; b_sbdata_i = 32'h0000_005A; b_data_wv = 1'b1;
        step();
        b_data_wv = 1'b0;
        chk("ai_req",   {63'd0, b_req}, 64'd1);
        chk("ai_be",    {60'd0, b_be}, 64'h8);
        chk("ai_wdata", {32'd0, b_wdata}, 64'h5A5A5A5A);
        step();
        chk("ai_hold1", {63'd0, b_req}, 64'd1);
        step();
        chk("ai_hold2", {32'd0, b_add}, 64'hFFFF_FFFF);
        b_gnt = 1'b1;
        step();
        b_gnt = 1'b0;
        chk("ai_req0", {63'd0, b_req}, 64'd0);
        b_rvalid = 1'b1;
        step();
        b_rvalid = 1'b0;
        chk("ai_addr",  {32'd0, b_sbaddress_o}, 64'd0);
        chk("ai_addrv", {63'd0, b_sbaddress_valid}, 64'd1);
        chk("ai_nodv",  {63'd0, b_sbdata_valid}, 64'd0);
        step();
        chk("ai_addrv_pulse", {63'd0, b_sbaddress_valid}, 64'd0);

        // Timeout: grant never comes, 8 cycles of request then error 1
        b_autoinc = 1'b0;
        b_sbaddress_i = 32'h100; b_sbaccess = 3'd2; b_addr_wv = 1'b1; b_rdonaddr = 1'b1;
        step();
        b_addr_wv = 1'b0; b_rdonaddr = 1'b0;
        req_cyc = 0;
        seen    = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (b_sberr_valid) seen = 1'b1;
            else begin
                if (b_req) req_cyc++;
                step();
            end
        end
        chk("to_seen",   {63'd0, seen}, 64'd1);
        chk("to_cycles", 64'(req_cyc), 64'd8);
        chk("to_err",    {61'd0, b_sberr}, 64'd1);
        chk("to_req",    {63'd0, b_req}, 64'd0);
        chk("to_busy",   {63'd0, b_busy}, 64'd0);
        b_rvalid = 1'b1; b_rdata = 32'hDEAD_BEEF;
        step();
        b_rvalid = 1'b0;
        chk("to_late_dv",  {63'd0, b_sbdata_valid}, 64'd0);
        chk("to_late_err", {63'd0, b_sberr_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
